// File: rtl/cpsr_flag_register.sv
// NZCV flag register with a single-level saved copy (SPSR) for exception entry/return.
// o_Next_CPSR exposes the value CPSR will take at the coming edge.
module cpsr_flag_register #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Result,
  input  logic             i_Carry_Out,
  input  logic             i_A_Msb,
  input  logic             i_B_Msb,
  input  logic [1:0]       i_Op_Class,
  input  logic             i_Set_Flags,
  input  logic             i_Cond_Pass,
  input  logic             i_Msr_Write,
  input  logic [3:0]       i_Msr_Data,
  input  logic             i_Exc_Entry,
  input  logic             i_Exc_Return,
  output logic [3:0]       o_CPSR,
  output logic [3:0]       o_SPSR,
  output logic [3:0]       o_Next_CPSR,
  output logic             o_Flags_Updated
);

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_NONE  = 2'b11;

  logic [3:0] r_CPSR;
  logic [3:0] r_SPSR;
  logic       r_Flags_Updated;
  logic [3:0] w_Alu_Flags;
  logic [3:0] w_Next_CPSR;

  // Subtract overflow uses the un-inverted B MSB, so the sign test is inverted vs. add.
  function automatic logic [3:0] alu_flags(
    input logic [WIDTH-1:0] res,
    input logic             carry,
    input logic             a_msb,
    input logic             b_msb,
    input logic [1:0]       op,
    input logic             v_cur
  );
    logic n;
    logic z;
    logic v;
    n = res[WIDTH-1];
    z = ~|res;
    case (op)
      OP_ADD:  v = (a_msb == b_msb) && (n != a_msb);
      OP_SUB:  v = (a_msb != b_msb) && (n != a_msb);
      default: v = v_cur;
    endcase
    return {n, z, carry, v};
  endfunction

  always_comb begin
    w_Alu_Flags = alu_flags(i_Result, i_Carry_Out, i_A_Msb, i_B_Msb, i_Op_Class, r_CPSR[0]);
  end

  // Entry leaves CPSR alone, so it shadows every lower-priority source in that cycle.
  always_comb begin
    w_Next_CPSR = r_CPSR;
    if (i_Reset)
      w_Next_CPSR = 4'b0000;
    else if (i_Exc_Entry)
      w_Next_CPSR = r_CPSR;
    else if (i_Exc_Return)
      w_Next_CPSR = r_SPSR;
    else if (i_Msr_Write && i_Cond_Pass)
      w_Next_CPSR = i_Msr_Data;
    else if (i_Set_Flags && i_Cond_Pass && (i_Op_Class != OP_NONE))
      w_Next_CPSR = w_Alu_Flags;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_CPSR          <= 4'b0000;
      r_SPSR          <= 4'b0000;
      r_Flags_Updated <= 1'b0;
    end else begin
      r_CPSR          <= w_Next_CPSR;
      r_Flags_Updated <= (w_Next_CPSR != r_CPSR);
      if (i_Exc_Entry)
        r_SPSR <= r_CPSR;
    end
  end

  assign o_CPSR          = r_CPSR;
  assign o_SPSR          = r_SPSR;
  assign o_Next_CPSR     = w_Next_CPSR;
  assign o_Flags_Updated = r_Flags_Updated;

  logic w_unused_op;
  assign w_unused_op = (OP_LOGIC == 2'b00) && (OP_SUB == 2'b10);

endmodule

// File: doc/cpsr_flag_register.md
Name: cpsr_flag_register

Overview:
- Produces and holds the NZCV flag word that the condition-check logic consumes. Flags come from ALU results on flag-setting (S-bit) instructions, from MSR-style writes, and from exception entry/return via a single saved copy (SPSR).
- Sits between the ALU/decoder and the condition checker in the single-cycle ARMv7 datapath.
- o_CPSR drives the condition checker's CPSR input directly.

Parameters:
WIDTH, 32, ALU result width in bits; sets the zero-detect width and the MSB position used for N.

Ports:
i_Clk  input  1  clock, all state updates on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Result  input  WIDTH  ALU result of the current instruction
i_Carry_Out  input  1  adder carry-out (add/sub) or shifter carry-out (logical)
i_A_Msb  input  1  MSB of ALU operand A
i_B_Msb  input  1  MSB of ALU operand B, un-inverted
i_Op_Class  input  2  00 logical, 01 add (A+B), 10 subtract (A-B), 11 no-flag op
i_Set_Flags  input  1  S bit of the current instruction
i_Cond_Pass  input  1  instruction's condition passed
i_Msr_Write  input  1  write i_Msr_Data into CPSR flags
i_Msr_Data  input  4  NZCV value for MSR write
i_Exc_Entry  input  1  exception entry: save CPSR into SPSR
i_Exc_Return  input  1  exception return: restore CPSR from SPSR
o_CPSR  output  4  registered flags {N,Z,C,V}
o_SPSR  output  4  registered saved flags {N,Z,C,V}
o_Next_CPSR  output  4  combinational value CPSR will take at the next edge
o_Flags_Updated  output  1  registered one-cycle pulse; CPSR changed value at the last edge

Behaviour:
- Reset (i_Reset high at an edge):
  - o_CPSR=0000, o_SPSR=0000, o_Flags_Updated=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-operation discards any pending update.
- Latency:
  - CPSR/SPSR update at the rising edge ending the instruction's cycle.
  - o_Next_CPSR is valid combinationally in the same cycle.
- Flag computation (ALU path):
  - N = i_Result[WIDTH-1].
  - Z = (i_Result == 0) across all WIDTH bits.
  - Add: C = i_Carry_Out; V = (A_Msb == B_Msb) & (Result_Msb != A_Msb).
  - Subtract: C = i_Carry_Out, following the ARM convention C = NOT borrow, with the adder computing A + ~B + 1. V = (A_Msb != B_Msb) & (Result_Msb != A_Msb).
  - Logical: N and Z as above; C = i_Carry_Out; V keeps its current value.
  - Op class 11: no flag change, regardless of the S bit.
- Update priority, highest first; only the highest active source acts in a cycle:
  1. i_Exc_Entry: SPSR <= CPSR; CPSR unchanged. Not gated by i_Cond_Pass.
  2. i_Exc_Return: CPSR <= SPSR; SPSR unchanged. Not gated by i_Cond_Pass.
  3. i_Msr_Write & i_Cond_Pass: CPSR <= i_Msr_Data.
  4. i_Set_Flags & i_Cond_Pass & (i_Op_Class != 11): CPSR <= computed flags.
  5. Otherwise: hold.
- Simultaneous events:
  - Entry and return together: entry wins; return is ignored that cycle.
  - Entry plus a flag-setting op: the op's flags are dropped, and SPSR captures the pre-instruction CPSR.
  - MSR plus S-op: MSR wins.
- o_Next_CPSR equals o_CPSR whenever no CPSR-updating source is active. During reset it shows 0000.
- o_Flags_Updated:
  - 1 for exactly one cycle after an edge where CPSR changed to a different value.
  - A write of an identical value gives 0.
  - Reset gives 0.
- SPSR is a single level. A nested entry overwrites it with no stacking.

Test Plan:
- Reset: drive random inputs with i_Reset=1 for 2 edges -> o_CPSR=0000, o_SPSR=0000, o_Flags_Updated=0; o_Next_CPSR=0000 during reset.
- SUBS 5-5: i_Result=0, i_Carry_Out=1, A_Msb=0, B_Msb=0, op=10, S=1, pass=1 -> next edge o_CPSR=0110 (N0 Z1 C1 V0); o_Flags_Updated=1 for one cycle.
- ADDS 0x7FFFFFFF+1: i_Result=0x80000000, i_Carry_Out=0, A_Msb=0, B_Msb=0, op=01 -> o_CPSR=1001. Follow with SUBS 0x80000000-1: result 0x7FFFFFFF, carry 1, A_Msb=1, B_Msb=0 -> o_CPSR=0011.
- Gating: from CPSR=1001, apply S=1/pass=0, then S=0/pass=1, then op=11/S=1/pass=1 -> o_CPSR stays 1001 and o_Flags_Updated stays 0 throughout.
- Logical keeps V: from CPSR=0011, ANDS with i_Result=0, i_Carry_Out=0, op=00 -> o_CPSR=0101 (V retained).
- Exceptions: from CPSR=1001, assert i_Exc_Entry together with an ADDS that would yield 0110 -> o_SPSR=1001, o_CPSR=1001. Then MSR 0000 with pass=1 -> o_CPSR=0000. Then assert i_Exc_Entry and i_Exc_Return together -> o_SPSR=0000, o_CPSR=0000. Then i_Exc_Return alone -> o_CPSR=0000.
